// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file, interrupt/mret trap sequencer and post-redirect flush window.
// Optional macro CSR_VECTORED_EN: mtvec[1:0] == 01 dispatches interrupts to base + 4*code.
module csr_trap_unit #(
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0100,
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_insn_vld,
    input  logic [31:0] i_pc,
    input  logic        i_csr_en,
    input  logic [2:0]  i_csr_op,
    input  logic        i_mret,
    input  logic [11:0] i_csr_addr,
    input  logic [31:0] i_csr_wdata,
    input  logic        i_src_zero,
    input  logic        i_irq_ext,
    input  logic        i_irq_timer,
    output logic [31:0] o_csr_rdata,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_flush,
    output logic        o_trap_taken
);
    typedef enum logic {IDLE, DRAIN} state_e;
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, code;
    logic [1:0]  ext_sync_q, tim_sync_q;
    logic        mst_mie_q, mst_mie_d, mpie_q, mpie_d, msip_q, msip_d;
    logic [31:0] mie_q, mie_d, mepc_q, mepc_d, mcause_q, mcause_d, mtvec_q, mtvec_d;
    logic [31:0] mstatus, mip, pend, old, upd, mtvec_wr, trap_pc, base;
    logic        commit, take, ret, we;
    assign mstatus = {24'b0, mpie_q, 3'b0, mst_mie_q, 3'b0};
    assign mip     = {20'b0, ext_sync_q[1], 3'b0, tim_sync_q[1], 3'b0, msip_q, 3'b0};
    assign pend    = mip & mie_q;
    assign commit  = i_rst_n && state_q == IDLE && i_insn_vld;
    assign take    = commit && mst_mie_q && pend != '0;
    assign ret     = commit && i_mret && !take;
    // RS/RC variants with a zero source are pure reads; op[1:0] == 00 is no access.
    assign we      = commit && !take && !i_mret && i_csr_en && i_csr_op[1:0] != 2'b00
                     && !(i_csr_op[1] && i_src_zero);
    assign code    = pend[11] ? 4'd11 : pend[3] ? 4'd3 : 4'd7;
    assign base    = {mtvec_q[31:2], 2'b00};
    assign upd     = i_csr_op[1:0] == 2'b01 ? i_csr_wdata :
                     i_csr_op[0] ? old & ~i_csr_wdata : old | i_csr_wdata;
`ifdef CSR_VECTORED_EN
    assign mtvec_wr = {upd[31:2], upd[1] ? 2'b00 : upd[1:0]};
    assign trap_pc  = mtvec_q[1:0] == 2'b01 ? base + {26'b0, code, 2'b00} : base;
`else
    assign mtvec_wr = {upd[31:2], 2'b00};
    assign trap_pc  = base;
`endif
    always_comb begin
        case (i_csr_addr)
            12'h300: old = mstatus;
            12'h304: old = mie_q;
            12'h305: old = mtvec_q;
            12'h341: old = mepc_q;
            12'h342: old = mcause_q;
            12'h344: old = mip;
            default: old = '0;
        endcase
    end
    assign o_csr_rdata   = (i_rst_n && i_csr_en && i_csr_op != 3'b000) ? old : '0;
    assign o_trap_taken  = take;
    assign o_redirect    = take || ret;
    assign o_redirect_pc = take ? trap_pc : ret ? mepc_q : '0;
    assign o_flush       = o_redirect || state_q == DRAIN;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mst_mie_d = mst_mie_q;
        mpie_d    = mpie_q;
        msip_d    = msip_q;
        mie_d     = mie_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        mtvec_d   = mtvec_q;
        if (state_q == DRAIN) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = cnt_q == 4'd1 ? IDLE : DRAIN;
        end else if (take || ret) begin
            cnt_d   = 4'(FLUSH_CYCLES);
            state_d = DRAIN;
        end
        if (take) begin
            mepc_d    = i_pc & ~32'h3;
            mcause_d  = {1'b1, 27'b0, code};
            mpie_d    = mst_mie_q;
            mst_mie_d = 1'b0;
        end else if (ret) begin
            mst_mie_d = mpie_q;
            mpie_d    = 1'b1;
        end else if (we) begin
            case (i_csr_addr)
                12'h300: begin
                    mst_mie_d = upd[3];
                    mpie_d    = upd[7];
                end
                12'h304: mie_d    = upd & 32'h0000_0888;
                12'h305: mtvec_d  = mtvec_wr;
                12'h341: mepc_d   = upd & ~32'h3;
                12'h342: mcause_d = upd;
                12'h344: msip_d   = upd[3];
                default: ;
            endcase
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ext_sync_q <= '0;
            tim_sync_q <= '0;
            mst_mie_q  <= 1'b0;
            mpie_q     <= 1'b0;
            msip_q     <= 1'b0;
            mie_q      <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
`ifdef CSR_VECTORED_EN
            mtvec_q    <= MTVEC_RESET;
`else
            mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ext_sync_q <= {ext_sync_q[0], i_irq_ext};
            tim_sync_q <= {tim_sync_q[0], i_irq_timer};
            mst_mie_q  <= mst_mie_d;
            mpie_q     <= mpie_d;
            msip_q     <= msip_d;
            mie_q      <= mie_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtvec_q    <= mtvec_d;
        end
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed scenarios plus random traffic, checked cycle by cycle against a behavioural CSR/trap model.
module tb_csr_trap_unit;
    localparam int FLUSH = 3;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        insn_vld, csr_en, mret, src_zero, irq_ext, irq_tim;
    logic [31:0] pc, wdata;
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] csr_rdata, redirect_pc;
    logic        redirect, flush, trap_taken;
    int          errors = 0, checks = 0;
    logic [31:0] m_mstatus, m_mie, m_msip, m_mepc, m_mcause, m_mtvec;
    int          drain;
    bit          ext_h[$], tim_h[$];
    logic [31:0] obs_rdata, obs_pc;
    logic        obs_redir, obs_flush, obs_trap;

    csr_trap_unit #(.MTVEC_RESET(32'h100), .FLUSH_CYCLES(FLUSH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_insn_vld(insn_vld), .i_pc(pc), .i_csr_en(csr_en),
        .i_csr_op(op), .i_mret(mret), .i_csr_addr(addr), .i_csr_wdata(wdata), .i_src_zero(src_zero),
        .i_irq_ext(irq_ext), .i_irq_timer(irq_tim), .o_csr_rdata(csr_rdata), .o_redirect(redirect),
        .o_redirect_pc(redirect_pc), .o_flush(flush), .o_trap_taken(trap_taken));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mstatus = 0; m_mie = 0; m_msip = 0; m_mepc = 0; m_mcause = 0; m_mtvec = 32'h100;
        drain = 0;
        ext_h = '{0, 0};
        tim_h = '{0, 0};
    endtask

    task automatic set(input bit v, input logic [31:0] p, input bit en, input logic [2:0] o,
                       input bit r, input logic [11:0] a, input logic [31:0] w, input bit sz);
        insn_vld = v; pc = p; csr_en = en; op = o; mret = r; addr = a; wdata = w; src_zero = sz;
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a, input logic [31:0] mip);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return mip;
            default: return 0;
        endcase
    endfunction

    // Called just after a rising edge with inputs already applied; checks, advances the model, waits one cycle.
    task automatic cycle();
        logic [31:0] mip, pend, old, nv, tgt;
        int code;
        bit commit, take, ret, wr;
        mip = (32'(ext_h[0]) << 11) | (32'(tim_h[0]) << 7) | m_msip;
        pend = mip & m_mie;
        commit = insn_vld && drain == 0;
        take = commit && m_mstatus[3] && pend != 0;
        ret = commit && mret && !take;
        old = model_read(addr, mip);
        code = pend[11] ? 11 : pend[3] ? 3 : 7;
        tgt = m_mtvec & ~32'h3;
`ifdef CSR_VECTORED_EN
        if (m_mtvec[1:0] == 2'b01) tgt = tgt + 4 * code;
`endif
        @(negedge clk);
        obs_rdata = csr_rdata; obs_pc = redirect_pc; obs_redir = redirect; obs_flush = flush; obs_trap = trap_taken;
        check("rdata", csr_rdata, (csr_en && op != 0) ? old : 0);
        check("trap_taken", 32'(trap_taken), 32'(take));
        check("redirect", 32'(redirect), 32'(take || ret));
        check("flush", 32'(flush), 32'(take || ret || drain > 0));
        if (take || ret) check("redirect_pc", redirect_pc, take ? tgt : m_mepc);
        wr = commit && !take && !mret && csr_en && op inside {1, 2, 3, 5, 6, 7}
             && !(src_zero && !(op inside {1, 5}));
        nv = (op inside {1, 5}) ? wdata : (op inside {2, 6}) ? (old | wdata) : (old & ~wdata);
        if (take) begin
            m_mepc = pc & ~32'h3;
            m_mcause = 32'h8000_0000 | code;
            m_mstatus = {24'b0, m_mstatus[3], 7'b0};
        end else if (ret) begin
            m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
        end else if (wr) begin
            case (addr)
                12'h300: m_mstatus = nv & 32'h88;
                12'h304: m_mie = nv & 32'h888;
`ifdef CSR_VECTORED_EN
                12'h305: m_mtvec = nv[1] ? nv & ~32'h3 : nv;
`else
                12'h305: m_mtvec = nv & ~32'h3;
`endif
                12'h341: m_mepc = nv & ~32'h3;
                12'h342: m_mcause = nv;
                12'h344: m_msip = nv & 32'h8;
                default: ;
            endcase
        end
        if (drain > 0) drain--;
        else if (take || ret) drain = FLUSH;
        @(posedge clk);
        ext_h.push_back(irq_ext); void'(ext_h.pop_front());
        tim_h.push_back(irq_tim); void'(tim_h.pop_front());
        #1;
    endtask

    task automatic csr(input logic [2:0] o, input logic [11:0] a, input logic [31:0] w);
        set(1, 32'h200, 1, o, 0, a, w, w == 0);
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set(0, 0, 0, 0, 0, 0, 0, 0);
            cycle();
        end
    endtask

    initial begin
        logic [11:0] addrs [7] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0};
        logic [2:0]  ops [7] = '{0, 1, 2, 3, 5, 6, 7};
        irq_ext = 0; irq_tim = 0;
        model_reset();
        set(1, 32'h40, 1, 3'b010, 1, 12'h305, 32'h1, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", csr_rdata, 0);
        check("rst_redirect", 32'(redirect), 0);
        check("rst_pc", redirect_pc, 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_trap", 32'(trap_taken), 0);
        rst_n = 1;
        idle(1);
        // mtvec write then set-bits write
        csr(3'b001, 12'h305, 32'h200);
        check("mtvec_rw_old", obs_rdata, 32'h100);
        csr(3'b010, 12'h305, 32'h3);
        check("mtvec_rs_old", obs_rdata, 32'h200);
        csr(3'b010, 12'h305, 0);
        check("mtvec_after", obs_rdata, 32'h200);
        csr(3'b001, 12'h305, 32'h100);
        // external interrupt
        csr(3'b001, 12'h304, 32'h800);
        csr(3'b001, 12'h300, 32'h8);
        irq_ext = 1;
        set(1, 32'h40, 0, 0, 0, 0, 0, 0);
        cycle();
        check("ext_sync1", 32'(obs_trap), 0);
        cycle();
        check("ext_sync2", 32'(obs_trap), 0);
        cycle();
        check("ext_take", 32'(obs_trap), 1);
        check("ext_target", obs_pc, 32'h100);
        for (int i = 0; i < FLUSH; i++) begin
            idle(1);
            check("ext_flush_win", 32'(obs_flush), 1);
        end
        idle(1);
        check("ext_flush_end", 32'(obs_flush), 0);
        irq_ext = 0;
        csr(3'b010, 12'h341, 0);
        check("ext_mepc", obs_rdata, 32'h40);
        csr(3'b010, 12'h342, 0);
        check("ext_mcause", obs_rdata, 32'h8000_000B);
        csr(3'b010, 12'h300, 0);
        check("ext_mstatus", obs_rdata, 32'h80);
        // mret
        csr(3'b001, 12'h341, 32'h44);
        set(1, 32'h60, 1, 0, 1, 0, 0, 0);
        cycle();
        check("mret_pc", obs_pc, 32'h44);
        idle(FLUSH);
        csr(3'b010, 12'h300, 0);
        check("mret_mstatus", obs_rdata, 32'h88);
        // interrupt beats mret
        irq_ext = 1;
        idle(2);
        set(1, 32'h80, 1, 3'b001, 1, 12'h342, 32'h55, 0);
        cycle();
        check("race_trap", 32'(obs_trap), 1);
        idle(FLUSH);
        irq_ext = 0;
        csr(3'b010, 12'h341, 0);
        check("race_mepc", obs_rdata, 32'h80);
        csr(3'b010, 12'h300, 0);
        check("race_mstatus", obs_rdata, 32'h80);
        // clear with zero source is a pure read
        csr(3'b001, 12'h304, 32'h888);
        set(1, 32'h200, 1, 3'b011, 0, 12'h304, 32'h888, 1);
        cycle();
        csr(3'b010, 12'h304, 0);
        check("rc_zero_mie", obs_rdata, 32'h888);
        // timer interrupt with mode bits 01
        csr(3'b001, 12'h305, 32'h101);
        csr(3'b001, 12'h304, 32'h80);
        csr(3'b001, 12'h300, 32'h8);
        irq_tim = 1;
        idle(2);
        set(1, 32'h90, 0, 0, 0, 0, 0, 0);
        cycle();
`ifdef CSR_VECTORED_EN
        check("timer_target", obs_pc, 32'h11C);
`else
        check("timer_target", obs_pc, 32'h100);
`endif
        irq_tim = 0;
        // reset in the middle of the drain window
        idle(1);
        set(1, 0, 1, 3'b010, 1, 12'h305, 0, 1);
        rst_n = 0;
        #1;
        check("drain_rst_flush", 32'(flush), 0);
        check("drain_rst_rdata", csr_rdata, 0);
        @(posedge clk);
        #1 rst_n = 1;
        model_reset();
        csr(3'b010, 12'h305, 0);
        check("drain_rst_mtvec", obs_rdata, 32'h100);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] w;
            w = $urandom_range(0, 3) == 0 ? 32'h888 : $urandom;
            set($urandom_range(0, 9) < 8, $urandom & 32'hFFFC, $urandom_range(0, 3) != 0,
                ops[$urandom_range(0, 6)], $urandom_range(0, 9) == 0, addrs[$urandom_range(0, 6)],
                w, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) irq_ext = ~irq_ext;
            if ($urandom_range(0, 19) == 0) irq_tim = ~irq_tim;
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
